uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters.
- Selects a requester, latches its byte and drives the transmitter's send/data inputs.
- Tracks the transmitter's active/done flags and returns a one-cycle ack to the served requester.
- Sits between client logic (command engines, debug ports) and the UART Tx top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 200000, clock cycles allowed per LAUNCH+SENDING before abort (only with the optional feature)

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level
req_data  in  8*NUM_REQ  flattened bytes; requester i in bits [8i+7:8i]
grant  out  NUM_REQ  one-hot; high while requester i owns the transmitter
ack  out  NUM_REQ  one-cycle pulse when requester i's byte has completed
tx_data  out  8  byte to transmitter data_in
tx_send  out  1  to transmitter send
tx_active  in  1  transmitter active flag
tx_done  in  1  transmitter done flag
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky abort indicator

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, ack=0, tx_data=0, tx_send=0, busy=0, timeout_err=0, pointer=NUM_REQ-1 (req[0] wins first).
- Clocking: tx_active and tx_done are produced from the same clock source and are sampled directly, with no synchroniser.
- IDLE:
  - If req!=0, pick the first set bit searching upward from pointer+1 with wrap.
  - Register grant, and latch tx_data from that requester's req_data slice.
  - Assert tx_send; go to LAUNCH. Latency is 1 cycle from req to grant/tx_send.
- LAUNCH: hold tx_send=1 and tx_data stable. When tx_active=1, deassert tx_send on the next edge and go to SENDING.
- SENDING: wait for tx_active=0 and tx_done=1, then go to DONE.
- DONE (1 cycle):
  - ack[i]=1 and grant cleared.
  - pointer=i; timeout_err cleared.
  - Go to IDLE.
  - The next arbitration happens in IDLE, so there is at least one idle cycle between bytes.
- Request rules:
  - req_data needs to be valid only in the grant cycle.
  - Dropping req after grant does not cancel the transfer; ack still pulses.
  - req dropped before grant means the requester is not served.
  - A requester wanting another byte keeps req high after ack. Round-robin then serves the other pending requesters first.
- All req set simultaneously: order is 0,1,2,3,0,... from reset.
- Single requester continuously asserting: served back-to-back, each separated by DONE+IDLE.
- tx_done high while in IDLE or LAUNCH is ignored; only the SENDING exit condition counts.
- reset_n asserted mid-transfer: immediate return to reset values. The transmitter is reset by the same reset_n.
- busy=1 in LAUNCH, SENDING and DONE.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter starts at 0 on entry to LAUNCH and runs through SENDING.
  - When it reaches TIMEOUT_CYCLES: tx_send=0, grant cleared, no ack, timeout_err=1 (sticky), pointer=i, go to IDLE.
  - timeout_err is cleared by the next DONE or by reset.
- Undefined: no counter is built, timeout_err is tied 0, and the block waits indefinitely.

Decomposition:
- Package uart_tx_pkg:
  - state typedef {IDLE, LAUNCH, SENDING, DONE};
  - UART_DATA_W=8;
  - UART_MAX_REQ=8.
- Sub-module uart_rr_pick: combinational round-robin selector (req, pointer -> one-hot, index, valid), reusable by a future Rx dispatcher.

Test Plan:
- Reset, then req=4'b0001, req_data[7:0]=8'hA5 -> grant=0001 and tx_send=1 one cycle later, tx_data=8'hA5; tx_send falls after tx_active rises; ack[0] pulses once after tx_done, busy=0 the cycle after.
- req=4'b1111 held, bytes 11/22/33/44 -> transmitted order 11,22,33,44,11; each ack pulse exactly 1 cycle; grant always one-hot.
- Pointer at 2, req=4'b0011 -> requester 0 granted before 1 (wrap-around).
- req[1] pulsed one cycle in IDLE then dropped -> byte still sent, ack[1] pulses.
- reset_n low during SENDING -> all outputs 0 asynchronously; after release, pending req[0] is served first.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, tx_active held 0 -> after 50 cycles tx_send=0, timeout_err=1, no ack; next successful byte clears timeout_err.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit-side arbitration blocks.
package uart_tx_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    SENDING = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request strictly after i_ptr, with wrap.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [PW-1:0] w_cand;
  logic          w_hit;

  // Scan N positions starting at i_ptr+1; the last position checked is i_ptr itself.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    w_hit    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand           = PW'((int'(i_ptr) + k) % N);
      w_hit            = !o_valid && i_req[w_cand];
      o_onehot[w_cand] = o_onehot[w_cand] | w_hit;
      o_idx            = w_hit ? w_cand : o_idx;
      o_valid          = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_TIMEOUT_EN to build the LAUNCH+SENDING abort timer.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_send,
  input  logic                           tx_active,
  input  logic                           tx_done,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int PW = $clog2(NUM_REQ);

  state_t                 r_state;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     r_ack;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_tx_send;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          r_idx;

  state_t                 w_state_nxt;
  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic [NUM_REQ-1:0]     w_ack_nxt;
  logic [UART_DATA_W-1:0] w_tx_data_nxt;
  logic                   w_tx_send_nxt;
  logic                   w_busy_nxt;
  logic                   w_terr_nxt;
  logic [PW-1:0]          w_ptr_nxt;
  logic [PW-1:0]          w_idx_nxt;

  logic [NUM_REQ-1:0]     w_pick_onehot;
  logic [PW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic [UART_DATA_W-1:0] w_pick_data;
  logic                   w_timeout;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_pick_data = req_data[{w_pick_idx, 3'b000} +: UART_DATA_W];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: zero in IDLE/DONE, so it starts at 0 on the first LAUNCH cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if ((r_state == LAUNCH) || (r_state == SENDING)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = ((r_state == LAUNCH) || (r_state == SENDING)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout            = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_tx_data_nxt = r_tx_data;
    w_tx_send_nxt = r_tx_send;
    w_terr_nxt    = r_timeout_err;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt   = LAUNCH;
          w_grant_nxt   = w_pick_onehot;
          w_idx_nxt     = w_pick_idx;
          w_tx_data_nxt = w_pick_data;
          w_tx_send_nxt = 1'b1;
        end else begin
          w_grant_nxt   = '0;
          w_tx_send_nxt = 1'b0;
        end
      end
      LAUNCH: begin
        // Timeout wins here so the counter can never run past its compare value.
        if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_tx_send_nxt = 1'b0;
          w_terr_nxt    = 1'b1;
          w_ptr_nxt     = r_idx;
        end else if (tx_active) begin
          w_state_nxt   = SENDING;
          w_tx_send_nxt = 1'b0;
        end else begin
          w_tx_send_nxt = 1'b1;
        end
      end
      SENDING: begin
        if (!tx_active && tx_done) begin
          w_state_nxt = DONE;
          w_ack_nxt   = r_grant;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_idx;
          w_terr_nxt  = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_tx_send_nxt = 1'b0;
          w_terr_nxt    = 1'b1;
          w_ptr_nxt     = r_idx;
        end else begin
          w_tx_send_nxt = 1'b0;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_grant_nxt   = '0;
        w_tx_send_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and registered outputs; pointer resets to the top so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_ack         <= '0;
      r_tx_data     <= '0;
      r_tx_send     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_ptr         <= PW'(NUM_REQ - 1);
      r_idx         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_ack         <= w_ack_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_send     <= w_tx_send_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_terr_nxt;
      r_ptr         <= w_ptr_nxt;
      r_idx         <= w_idx_nxt;
    end
  end

  assign grant       = r_grant;
  assign ack         = r_ack;
  assign tx_data     = r_tx_data;
  assign tx_send     = r_tx_send;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, short timeout parameter).
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_active;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        act;
    logic        done;
    logic [3:0]  g;
    logic [3:0]  a;
    logic [7:0]  d;
    logic        s;
    logic        b;
  } vec_t;

  vec_t vecs[$];

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkv(input logic [3:0] r, input logic [31:0] dt, input logic a,
                               input logic dn, input logic [3:0] eg, input logic [3:0] ea,
                               input logic [7:0] ed, input logic es, input logic eb);
    vec_t v;
    v.req = r; v.data = dt; v.act = a; v.done = dn;
    v.g = eg; v.a = ea; v.d = ed; v.s = es; v.b = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0000_0000;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_send(input string name);
    int n;
    n = 0;
    while ((tx_send !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    chk({name, "_send_seen"}, 32'(tx_send), 32'd1);
  endtask

  // One complete byte: grant/data check, active handshake, one-cycle ack, then idle.
  task automatic serve(input int exp_i, input logic [7:0] exp_b);
    string nm;
    nm = $sformatf("serve%0d_%h", exp_i, exp_b);
    wait_send(nm);
    chk({nm, "_grant"}, 32'(grant), 32'd1 << exp_i);
    chk({nm, "_data"}, 32'(tx_data), 32'(exp_b));
    tx_active = 1'b1;
    tick();
    chk({nm, "_send_low"}, 32'({tx_send, busy}), 32'b01);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    chk({nm, "_ack"}, 32'({ack, grant, busy}), 32'({4'(32'd1 << exp_i), 4'b0000, 1'b1}));
    tx_done = 1'b0;
    tick();
    chk({nm, "_idle"}, 32'({ack, busy}), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0000_0000;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    #2;
    chk("reset_outputs", 32'({grant, ack, tx_data, tx_send, busy, timeout_err}), 32'd0);
    tick();
    reset_n = 1'b1;

    // Single byte from requester 0, tx_done ignored in IDLE afterwards.
    vecs.push_back(mkv(4'b0001, 32'h0000_00A5, 1'b0, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 8'hA5, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0));
    // req[1] pulsed for one cycle; tx_done in LAUNCH and a lone active drop are ignored.
    vecs.push_back(mkv(4'b0010, 32'h0000_5C00, 1'b0, 1'b0, 4'b0010, 4'b0000, 8'h5C, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 8'h5C, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 8'h5C, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 8'h5C, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0010, 8'h5C, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h5C, 1'b0, 1'b0));
    // Move pointer to 2, then req=0011 must wrap to requester 0 before 1.
    vecs.push_back(mkv(4'b0100, 32'h0077_0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 8'h77, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 8'h77, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 8'h77, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h77, 1'b0, 1'b0));
    vecs.push_back(mkv(4'b0011, 32'h0000_2211, 1'b0, 1'b0, 4'b0001, 4'b0000, 8'h11, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0011, 32'h0000_2211, 1'b1, 1'b0, 4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0011, 32'h0000_2211, 1'b0, 1'b1, 4'b0000, 4'b0001, 8'h11, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0011, 32'h0000_2211, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h11, 1'b0, 1'b0));
    vecs.push_back(mkv(4'b0011, 32'h0000_2211, 1'b0, 1'b0, 4'b0010, 4'b0000, 8'h22, 1'b1, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 8'h22, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0010, 8'h22, 1'b0, 1'b1));
    vecs.push_back(mkv(4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h22, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      req       = vecs[i].req;
      req_data  = vecs[i].data;
      tx_active = vecs[i].act;
      tx_done   = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i), 32'({grant, ack, tx_data, tx_send, busy, timeout_err}),
          32'({vecs[i].g, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].b, 1'b0}));
    end

    // All requesters held: order 0,1,2,3,0 from reset.
    do_reset();
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    serve(0, 8'h11);
    serve(1, 8'h22);
    serve(2, 8'h33);
    serve(3, 8'h44);
    serve(0, 8'h11);
    req = 4'b0000;
    tick();
    tick();

    // Reset during SENDING clears outputs asynchronously; pending req[0] served first after.
    req      = 4'b0100;
    req_data = 32'h0066_0000;
    wait_send("rst_mid");
    chk("rst_mid_grant", 32'(grant), 32'b0100);
    req       = 4'b0000;
    tx_active = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_async", 32'({grant, ack, tx_data, tx_send, busy, timeout_err}), 32'd0);
    tx_active = 1'b0;
    req       = 4'b0011;
    req_data  = 32'h0000_BBAA;
    tick();
    reset_n = 1'b1;
    serve(0, 8'hAA);
    serve(1, 8'hBB);
    req = 4'b0000;
    tick();

`ifdef UART_TX_ARB_TIMEOUT_EN
    // tx_active never rises: abort after 50 LAUNCH cycles, no ack, sticky error.
    req      = 4'b0001;
    req_data = 32'h0000_00C3;
    wait_send("tmo");
    req = 4'b0000;
    repeat (49) tick();
    chk("tmo_before", 32'({tx_send, timeout_err, busy}), 32'b101);
    tick();
    chk("tmo_abort", 32'({tx_send, timeout_err, ack, grant, busy}), 32'({1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0}));
    tick();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    req      = 4'b0001;
    req_data = 32'h0000_003C;
    serve(0, 8'h3C);
    req = 4'b0000;
    chk("tmo_cleared", 32'(timeout_err), 32'd0);
`else
    // Without the timer the block waits indefinitely for tx_active.
    req      = 4'b0001;
    req_data = 32'h0000_00C3;
    wait_send("notmo");
    req = 4'b0000;
    repeat (60) tick();
    chk("notmo_wait", 32'({tx_send, busy, timeout_err, grant}), 32'({1'b1, 1'b1, 1'b0, 4'b0001}));
    serve(0, 8'hC3);
    chk("notmo_err", 32'(timeout_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
